// File: rtl/sii_cfg_pkg.sv
// rtl/sii_cfg_pkg.sv - shared states, ops, table layout and divider helper for the SII I2C config sequencer
package sii_cfg_pkg;

  // Top-level sequencer states
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_LO,
    ST_RST_WAIT,
    ST_FETCH,
    ST_START,
    ST_BYTE,
    ST_ACK,
    ST_STOP,
    ST_FIN
  } cfg_state_e;

  // Bus phases the bit engine can run
  typedef enum logic [1:0] {
    OP_START,
    OP_BYTE,
    OP_ACK,
    OP_STOP
  } i2c_op_e;

  // Table entry layout: {dev_addr[7:1], 1'b0, reg[7:0], data[7:0]}
  localparam int DEV_MSB = 23;
  localparam int REG_MSB = 15;
  localparam int DAT_MSB = 7;

  // clk cycles per quarter SCL period
  function automatic int qdiv_calc(input int clk_hz, input int i2c_hz);
    return clk_hz / (4 * i2c_hz);
  endfunction

endpackage

// File: rtl/i2c_byte_tx.sv
// rtl/i2c_byte_tx.sv - quarter-tick I2C bit engine (start, byte, ack, stop); optional I2C_STRETCH_EN honours clock stretching
module i2c_byte_tx
  import sii_cfg_pkg::*;
#(
  parameter int QDIV = 62
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       go,
  input  i2c_op_e    op,
  input  logic [7:0] byte_in,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       phase_done,
  output logic       nack
);

  logic [15:0] qcnt;
  logic        tick;
  logic        hold;
  logic        active;
  i2c_op_e     op_r;
  logic [2:0]  qn;
  logic [2:0]  bitn;
  logic        last_q;
  logic        nack_r;

`ifdef I2C_STRETCH_EN
  // A released SCL that still reads low is being stretched by the slave
  assign hold = active && !scl_oe && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign hold = 1'b0;
`endif

  assign tick       = (qcnt == 16'(QDIV - 1)) && !hold;
  assign last_q     = (op_r == OP_STOP) ? (qn == 3'd6) : (qn == 3'd3);
  assign phase_done = active && tick && last_q && ((op_r != OP_BYTE) || (bitn == 3'd7));
  assign nack       = nack_r;

  // Quarter divider plus per-quarter line actions; STOP adds 4 quarters of bus-free time
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      qcnt   <= 16'd0;
      active <= 1'b0;
      op_r   <= OP_START;
      qn     <= 3'd0;
      bitn   <= 3'd0;
      scl_oe <= 1'b0;
      sda_oe <= 1'b0;
      nack_r <= 1'b0;
    end else begin
      if (!hold) begin
        qcnt <= (qcnt == 16'(QDIV - 1)) ? 16'd0 : qcnt + 16'd1;
      end
      if (!active) begin
        if (go) begin
          active <= 1'b1;
          op_r   <= op;
          qn     <= 3'd0;
          bitn   <= 3'd0;
        end
      end else if (tick) begin
        unique case (op_r)
          OP_START: begin
            if (qn == 3'd0) begin scl_oe <= 1'b0; sda_oe <= 1'b0; end
            if (qn == 3'd2) sda_oe <= 1'b1;
            if (qn == 3'd3) scl_oe <= 1'b1;
          end
          OP_BYTE: begin
            if (qn == 3'd0) sda_oe <= ~byte_in[3'd7 - bitn];
            if (qn == 3'd1) scl_oe <= 1'b0;
            if (qn == 3'd3) scl_oe <= 1'b1;
          end
          OP_ACK: begin
            if (qn == 3'd0) sda_oe <= 1'b0;
            if (qn == 3'd1) scl_oe <= 1'b0;
            if (qn == 3'd2) nack_r <= sda_in;
            if (qn == 3'd3) scl_oe <= 1'b1;
          end
          OP_STOP: begin
            if (qn == 3'd0) sda_oe <= 1'b1;
            if (qn == 3'd1) scl_oe <= 1'b0;
            if (qn == 3'd2) sda_oe <= 1'b0;
          end
        endcase
        if (last_q) begin
          qn <= 3'd0;
          if ((op_r == OP_BYTE) && (bitn != 3'd7)) bitn <= bitn + 3'd1;
          else                                     active <= 1'b0;
        end else begin
          qn <= qn + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/sii_i2c_cfg_seq.sv
// rtl/sii_i2c_cfg_seq.sv - SII9136/SII9233 I2C config sequencer top; I2C_STRETCH_EN enables slave clock stretching
module sii_i2c_cfg_seq
  import sii_cfg_pkg::*;
#(
  parameter int CLK_HZ     = 25000000,
  parameter int I2C_HZ     = 100000,
  parameter int TBL_AW     = 6,
  parameter int RST_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [TBL_AW-1:0] err_idx,
  output logic              chip_reset_,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [23:0]       tbl_data,
  output logic              scl_oe,
  output logic              sda_oe,
  input  logic              scl_in,
  input  logic              sda_in
);

  localparam int QDIV = qdiv_calc(CLK_HZ, I2C_HZ);

  cfg_state_e  state, nxt;
  logic [31:0] rst_cnt;
  logic        rst_last;
  logic        fetch_ph;
  logic [23:0] sr;
  logic [1:0]  byte_cnt;
  logic        eng_go;
  i2c_op_e     eng_op;
  logic        eng_done;
  logic        eng_nack;
  logic        end_of_tbl;
  logic        walk_over;

  assign rst_last   = (rst_cnt == 32'(RST_CYCLES - 1));
  assign end_of_tbl = (tbl_data[DEV_MSB:DEV_MSB-6] == 7'd0);
  assign walk_over  = error || (&tbl_addr);

  i2c_byte_tx #(.QDIV(QDIV)) u_tx (
    .clk        (clk),
    .reset      (reset),
    .en         (state != ST_IDLE),
    .go         (eng_go),
    .op         (eng_op),
    .byte_in    (sr[DEV_MSB -: 8]),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .phase_done (eng_done),
    .nack       (eng_nack)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  // Next state and bit-engine command; the engine runs while go is held in a bus state
  always_comb begin
    nxt    = state;
    eng_go = 1'b0;
    eng_op = OP_START;
    case (state)
      ST_IDLE:     if (start) nxt = ST_RST_LO;
      ST_RST_LO:   if (rst_last) nxt = ST_RST_WAIT;
      ST_RST_WAIT: if (rst_last) nxt = ST_FETCH;
      ST_FETCH:    if (fetch_ph) nxt = end_of_tbl ? ST_FIN : ST_START;
      ST_START: begin
        eng_go = 1'b1;
        eng_op = OP_START;
        if (eng_done) nxt = ST_BYTE;
      end
      ST_BYTE: begin
        eng_go = 1'b1;
        eng_op = OP_BYTE;
        if (eng_done) nxt = ST_ACK;
      end
      ST_ACK: begin
        eng_go = 1'b1;
        eng_op = OP_ACK;
        if (eng_done) nxt = (eng_nack || (byte_cnt == 2'd2)) ? ST_STOP : ST_BYTE;
      end
      ST_STOP: begin
        eng_go = 1'b1;
        eng_op = OP_STOP;
        if (eng_done) nxt = walk_over ? ST_FIN : ST_FETCH;
      end
      ST_FIN:  nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Reset timing, table walk, shift register and sticky status
  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_idx     <= '0;
      chip_reset_ <= 1'b1;
      tbl_addr    <= '0;
      rst_cnt     <= 32'd0;
      fetch_ph    <= 1'b0;
      sr          <= 24'd0;
      byte_cnt    <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          chip_reset_ <= 1'b0;
          tbl_addr    <= '0;
          done        <= 1'b0;
          error       <= 1'b0;
          busy        <= 1'b1;
          rst_cnt     <= 32'd0;
        end
        ST_RST_LO: begin
          rst_cnt <= rst_last ? 32'd0 : rst_cnt + 32'd1;
          if (rst_last) chip_reset_ <= 1'b1;
        end
        ST_RST_WAIT: rst_cnt <= rst_last ? 32'd0 : rst_cnt + 32'd1;
        ST_FETCH: begin
          fetch_ph <= ~fetch_ph;
          if (fetch_ph) sr <= tbl_data;
        end
        ST_START: byte_cnt <= 2'd0;
        ST_ACK: if (eng_done) begin
          if (eng_nack) begin
            error   <= 1'b1;
            err_idx <= tbl_addr;
          end else begin
            byte_cnt <= byte_cnt + 2'd1;
            sr       <= {sr[15:0], 8'h00};
          end
        end
        ST_STOP: if (eng_done && !walk_over) tbl_addr <= tbl_addr + TBL_AW'(1);
        ST_FIN: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sii_i2c_cfg_seq.sv
// tb/tb_sii_i2c_cfg_seq.sv - directed bench: ROM model, ACKing/NACKing slave and bus decoder for sii_i2c_cfg_seq
module tb_sii_i2c_cfg_seq;

  localparam int CLK_HZ  = 1600000;
  localparam int I2C_HZ  = 100000;
  localparam int TBL_AW  = 6;
  localparam int RST_CYC = 20;
  localparam int QDIV    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, start;
  logic              busy, done, error, chip_reset_, scl_oe, sda_oe;
  logic [TBL_AW-1:0] err_idx, tbl_addr;
  logic [23:0]       tbl_data;
  logic              scl, sda;
  logic              slave_sda_low = 1'b0;
  logic              slave_scl_hold = 1'b0;
  logic [23:0]       rom [64];

  assign scl = ~scl_oe & ~slave_scl_hold;
  assign sda = ~sda_oe & ~slave_sda_low;

  sii_i2c_cfg_seq #(
    .CLK_HZ(CLK_HZ), .I2C_HZ(I2C_HZ), .TBL_AW(TBL_AW), .RST_CYCLES(RST_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
    .err_idx(err_idx), .chip_reset_(chip_reset_), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl), .sda_in(sda)
  );

  // Config ROM with one cycle of read latency
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  int   cyc = 0, s_cnt = 0, p_cnt = 0, lo_cnt = 0;
  int   log_q[$];
  int   rise_q[$];
  int   bitn = 0, byte_idx = 0, nack_txn = -1, nack_byte = -1;
  logic [7:0] shreg = 8'h00;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  logic stretch_arm = 1'b0, stretch_used = 1'b0, hold_on = 1'b0;
  int   hold_cnt = 0;

  // Bus decoder and slave: logs S/P and bytes ({ack ? 4 : 8, byte}), ACKs unless told to NACK
  always @(posedge clk) begin
    cyc++;
    if (chip_reset_ === 1'b0) lo_cnt++;
    if (prev_scl && scl && prev_sda && !sda) begin
      s_cnt++; log_q.push_back('h100); bitn = 0; byte_idx = 0;
    end else if (prev_scl && scl && !prev_sda && sda) begin
      p_cnt++; log_q.push_back('h200);
    end
    if (!prev_scl && scl) begin
      rise_q.push_back(cyc);
      if (bitn < 8) begin shreg = {shreg[6:0], sda}; bitn++; end
      else begin log_q.push_back((sda ? 'h800 : 'h400) | int'(shreg)); bitn = 0; byte_idx++; end
    end
    if (prev_scl && !scl) begin
      if (bitn == 8 && !((s_cnt - 1) == nack_txn && byte_idx == nack_byte)) slave_sda_low <= 1'b1;
      else slave_sda_low <= 1'b0;
    end
`ifdef I2C_STRETCH_EN
    if (prev_scl && !scl && bitn == 3 && stretch_arm && !stretch_used) begin
      stretch_used = 1'b1; hold_on = 1'b1; hold_cnt = 0; slave_scl_hold <= 1'b1;
    end else if (hold_on && !scl_oe) begin
      hold_cnt++;
      if (hold_cnt == 500) begin hold_on = 1'b0; slave_scl_hold <= 1'b0; end
    end
`endif
    prev_scl = scl;
    prev_sda = sda;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_done"}, done, 1'b1);
  endtask

  int base_log, base_r, s0, p0, l0, n;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 24'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_idx", err_idx, 0);
    chk("rst_chip_reset_", chip_reset_, 1);
    chk("rst_tbl_addr", tbl_addr, 0);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    reset = 1'b0;

    // single entry, all bytes ACKed
    rom[0] = 24'h721E00; rom[1] = 24'h0;
    base_log = log_q.size(); base_r = rise_q.size(); l0 = lo_cnt;
    pulse_start();
    chk("t1_busy_after_start", busy, 1);
    chk("t1_chip_reset_low", chip_reset_, 0);
    wait_done("t1", 5000);
    chk("t1_reset_low_cycles", lo_cnt - l0, RST_CYC);
    chk("t1_tok_s", log_q[base_log], 'h100);
    chk("t1_tok_dev", log_q[base_log + 1], 'h472);
    chk("t1_tok_reg", log_q[base_log + 2], 'h41E);
    chk("t1_tok_dat", log_q[base_log + 3], 'h400);
    chk("t1_tok_p", log_q[base_log + 4], 'h200);
    chk("t1_error", error, 0);
    chk("t1_busy", busy, 0);
    chk("t1_tbl_addr", tbl_addr, 1);
    chk("t1_scl_period", rise_q[base_r + 1] - rise_q[base_r], 4 * QDIV);
    chk("t1_scl_period_b3", rise_q[base_r + 3] - rise_q[base_r + 2], 4 * QDIV);

    // NACK on register byte of entry 2
    rom[0] = 24'h721E00; rom[1] = 24'h721F01; rom[2] = 24'h722002; rom[3] = 24'h722103; rom[4] = 24'h0;
    nack_txn = s_cnt + 2; nack_byte = 1; s0 = s_cnt; p0 = p_cnt;
    pulse_start();
    wait_done("t2", 8000);
    chk("t2_starts", s_cnt - s0, 3);
    chk("t2_stops", p_cnt - p0, 3);
    chk("t2_error", error, 1);
    chk("t2_err_idx", err_idx, 2);
    chk("t2_tbl_addr", tbl_addr, 2);
    chk("t2_nack_tok", log_q[log_q.size() - 2], 'h820);
    chk("t2_last_p", log_q[log_q.size() - 1], 'h200);
    nack_txn = -1;

    // empty table
    rom[0] = 24'h0;
    base_r = rise_q.size();
    pulse_start();
    wait_done("t3", 3000);
    chk("t3_scl_edges", rise_q.size() - base_r, 0);
    chk("t3_error_cleared", error, 0);
    chk("t3_tbl_addr", tbl_addr, 0);

    // second start while busy is ignored
    rom[0] = 24'h721E00; rom[1] = 24'h0;
    s0 = s_cnt;
    pulse_start();
    repeat (100) @(negedge clk);
    chk("t4_busy_mid", busy, 1);
    pulse_start();
    wait_done("t4", 5000);
    repeat (60) @(negedge clk);
    chk("t4_txn_count", s_cnt - s0, 1);
    chk("t4_busy_after", busy, 0);
    chk("t4_done_kept", done, 1);

`ifdef I2C_STRETCH_EN
    // slave stretches bit 3 of the address byte by 500 cycles
    base_log = log_q.size(); base_r = rise_q.size();
    stretch_arm = 1'b1;
    pulse_start();
    wait_done("t5", 6000);
    chk("t5_stretch_period", rise_q[base_r + 3] - rise_q[base_r + 2], 4 * QDIV + 500);
    chk("t5_after_period", rise_q[base_r + 4] - rise_q[base_r + 3], 4 * QDIV);
    chk("t5_tok_dev", log_q[base_log + 1], 'h472);
    chk("t5_tok_reg", log_q[base_log + 2], 'h41E);
`endif

    // reset in the middle of the address byte while both lines are driven
    base_r = rise_q.size();
    pulse_start();
    n = 0;
    while (!((rise_q.size() - base_r >= 5) && scl_oe && sda_oe) && n < 3000) begin
      @(negedge clk); n++;
    end
    chk("t6_reached_mid_byte", scl_oe & sda_oe, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_scl_released", scl_oe, 0);
    chk("t6_sda_released", sda_oe, 0);
    chk("t6_busy", busy, 0);
    chk("t6_chip_reset_", chip_reset_, 1);
    reset = 1'b0;
    repeat (2 * QDIV) @(negedge clk);
    chk("t6_idle_scl", scl_oe, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
